// File: rtl/oversampled_tx_serializer.sv
// Byte-to-line-sample serializer: each bit is replicated OVERSAMPLE times into SAMPLES_PER_CLK
// samples per clk, with idle-bit fill on underflow and single-sample phase-slip injection.
module oversampled_tx_serializer #(
  parameter int                         SAMPLES_PER_CLK = 8,
  parameter int                         OVERSAMPLE      = 4,
  parameter logic [SAMPLES_PER_CLK-1:0] INV_MASK        = 8'hAA
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 s_tdata,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  logic                       ph_inc,
  input  logic                       ph_dec,
  output logic                       slip_busy,
  output logic [SAMPLES_PER_CLK-1:0] tx_samples,
  output logic                       underflow
);

  localparam int CW = $clog2(OVERSAMPLE + 2);
  localparam int SW = (SAMPLES_PER_CLK > 1) ? $clog2(SAMPLES_PER_CLK) : 1;

  logic [15:0]                bit_buf;
  logic [4:0]                 fill;
  logic                       cur_bit;
  logic [CW-1:0]              cur_cnt;
  logic                       pend_inc;
  logic                       pend_dec;

  logic [15:0]                nxt_buf;
  logic [4:0]                 nxt_fill;
  logic                       nxt_bit;
  logic [CW-1:0]              nxt_cnt;
  logic                       nxt_pinc;
  logic                       nxt_pdec;
  logic [SAMPLES_PER_CLK-1:0] raw;
  logic                       idle_seen;

  assign s_tready  = !rst && (fill <= 5'd8);
  assign slip_busy = pend_inc | pend_dec;

  always_comb begin
    nxt_buf   = bit_buf;
    nxt_fill  = fill;
    nxt_bit   = cur_bit;
    nxt_cnt   = cur_cnt;
    nxt_pinc  = pend_inc;
    nxt_pdec  = pend_dec;
    raw       = '0;
    idle_seen = 1'b0;

    // A bit loads lazily at the first sample slot where the previous one is exhausted.
    for (int unsigned i = 0; i < SAMPLES_PER_CLK; i++) begin
      if (nxt_cnt == '0) begin
        if (nxt_fill != '0) begin
          nxt_bit  = nxt_buf[15];
          nxt_buf  = {nxt_buf[14:0], 1'b0};
          nxt_fill = nxt_fill - 5'd1;
        end else begin
          nxt_bit   = ~nxt_bit;
          idle_seen = 1'b1;
        end
        if (nxt_pinc)
          nxt_cnt = CW'(OVERSAMPLE + 1);
        else if (nxt_pdec)
          nxt_cnt = CW'(OVERSAMPLE - 1);
        else
          nxt_cnt = CW'(OVERSAMPLE);
        nxt_pinc = 1'b0;
        nxt_pdec = 1'b0;
      end
      raw[SW'(SAMPLES_PER_CLK - 1 - i)] = nxt_bit;
      nxt_cnt = nxt_cnt - 1'b1;
    end

    // Append after this cycle's consumption; fill <= 8 guarantees the byte fits.
    if (s_tvalid && s_tready) begin
      for (int unsigned j = 0; j < 8; j++)
        nxt_buf[4'(15 - 32'(nxt_fill) - j)] = s_tdata[3'(7 - j)];
      nxt_fill = nxt_fill + 5'd8;
    end

    if (!slip_busy && (ph_inc ^ ph_dec)) begin
      nxt_pinc = ph_inc;
      nxt_pdec = ph_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_buf    <= '0;
      fill       <= '0;
      cur_bit    <= 1'b0;
      cur_cnt    <= '0;
      pend_inc   <= 1'b0;
      pend_dec   <= 1'b0;
      tx_samples <= INV_MASK;
      underflow  <= 1'b0;
    end else begin
      bit_buf    <= nxt_buf;
      fill       <= nxt_fill;
      cur_bit    <= nxt_bit;
      cur_cnt    <= nxt_cnt;
      pend_inc   <= nxt_pinc;
      pend_dec   <= nxt_pdec;
      tx_samples <= raw ^ INV_MASK;
      underflow  <= idle_seen;
    end
  end

endmodule
